// File: rtl/instr_encoder.sv
// Pipelined RV32I encoder: decoded descriptor -> 32-bit machine word plus illegal-descriptor flag.
// Optional saturating word/error counters are built when INSTR_ENCODER_STATS_EN is defined.
module instr_encoder #(
  parameter int IMM_CHECK = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic             in_f7b5,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] stat_enc,
  output logic [CNT_W-1:0] stat_err
);

  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_FENCE  = 5'b00011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;
  localparam logic       CHK        = (IMM_CHECK != 0);

  logic [6:0]  opc;
  logic        i_ok, b_ok, j_ok;
  logic [31:0] enc;
  logic        bad_fn, bad_imm;
  logic [31:0] enc_word;
  logic        enc_err;

  logic        s1_valid, s1_err;
  logic [31:0] s1_instr;
  logic        s2_valid, s2_err;
  logic [31:0] s2_instr;
  logic        accept, s2_adv;

  assign opc  = {in_opcode, 2'b11};
  // Range checks: upper bits must be pure sign extension of the field's top bit.
  assign i_ok = (in_imm[31:11] == {21{in_imm[11]}});
  assign b_ok = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];
  assign j_ok = (in_imm[31:20] == {12{in_imm[20]}}) && !in_imm[0];

  always_comb begin
    enc     = 32'h0;
    bad_fn  = 1'b0;
    bad_imm = 1'b0;
    case (in_opcode)
      OPC_OP: begin
        enc    = {1'b0, in_f7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, opc};
        bad_fn = in_f7b5 && (in_funct3 != 3'b000) && (in_funct3 != 3'b101);
      end
      OPC_OPIMM: begin
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101) begin
          enc     = {1'b0, in_f7b5, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd, opc};
          bad_fn  = in_f7b5 && (in_funct3 != 3'b101);
          bad_imm = (in_imm[31:5] != 27'd0);
        end else begin
          enc     = {in_imm[11:0], in_rs1, in_funct3, in_rd, opc};
          bad_imm = !i_ok;
        end
      end
      OPC_LOAD: begin
        enc     = {in_imm[11:0], in_rs1, in_funct3, in_rd, opc};
        bad_fn  = (in_funct3 == 3'b011) || (in_funct3 == 3'b110) || (in_funct3 == 3'b111);
        bad_imm = !i_ok;
      end
      OPC_JALR: begin
        enc     = {in_imm[11:0], in_rs1, in_funct3, in_rd, opc};
        bad_fn  = (in_funct3 != 3'b000);
        bad_imm = !i_ok;
      end
      OPC_STORE: begin
        enc     = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], opc};
        bad_fn  = (in_funct3 > 3'b010);
        bad_imm = !i_ok;
      end
      OPC_BRANCH: begin
        enc     = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                   in_imm[4:1], in_imm[11], opc};
        bad_fn  = (in_funct3[2:1] == 2'b01);
        bad_imm = !b_ok;
      end
      OPC_LUI, OPC_AUIPC: begin
        enc     = {in_imm[31:12], in_rd, opc};
        bad_imm = (in_imm[11:0] != 12'd0);
      end
      OPC_JAL: begin
        enc     = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
        bad_imm = !j_ok;
      end
      OPC_FENCE: begin
        enc     = {in_imm[11:0], 5'b00000, 3'b000, 5'b00000, opc};
        bad_imm = !i_ok;
      end
      OPC_SYSTEM: begin
        if (in_imm == 32'd0)      enc = 32'h0000_0073;
        else if (in_imm == 32'd1) enc = 32'h0010_0073;
        else                      bad_fn = 1'b1;
      end
      default: bad_fn = 1'b1;
    endcase
  end

  assign enc_err  = bad_fn || (CHK && bad_imm);
  assign enc_word = enc_err ? 32'h0 : enc;

  assign in_ready = !s1_valid || !s2_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign s2_adv   = s1_valid && (!s2_valid || out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_instr <= 32'h0;
      s1_err   <= 1'b0;
      s2_valid <= 1'b0;
      s2_instr <= 32'h0;
      s2_err   <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_instr <= enc_word;
        s1_err   <= enc_err;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
      // S2 only reloads when it is empty or its word leaves this cycle, so held outputs stay stable.
      if (s2_adv) begin
        s2_valid <= 1'b1;
        s2_instr <= s1_instr;
        s2_err   <= s1_err;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_instr = s2_instr;
  assign out_err   = s2_err;

`ifdef INSTR_ENCODER_STATS_EN
  logic [CNT_W-1:0] enc_cnt, err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_cnt <= '0;
      err_cnt <= '0;
    end else if (s2_valid && out_ready) begin
      if (enc_cnt != '1)           enc_cnt <= enc_cnt + CNT_W'(1);
      if (s2_err && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  assign stat_enc = enc_cnt;
  assign stat_err = err_cnt;
`else
  assign stat_enc = '0;
  assign stat_err = '0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder: encodings, error cases, latency, backpressure, reset, stats.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_opcode = 5'b0;
  logic [4:0]  in_rd = 5'b0;
  logic [4:0]  in_rs1 = 5'b0;
  logic [4:0]  in_rs2 = 5'b0;
  logic [2:0]  in_funct3 = 3'b0;
  logic        in_f7b5 = 1'b0;
  logic [31:0] in_imm = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] stat_enc, stat_err;

  int vectors = 0;
  int fails   = 0;

  instr_encoder #(.IMM_CHECK(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .stat_enc(stat_enc), .stat_err(stat_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_desc(input logic [4:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                          input logic [31:0] imm);
    in_opcode = opc; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3;  in_f7b5 = f7; in_imm = imm;
  endtask

  // Entered #1 after a rising edge with out_ready=1 and the pipeline empty.
  task automatic encode_one(input string tag, input logic [4:0] opc, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic f7, input logic [31:0] imm,
                            input logic [31:0] exp_instr, input logic exp_err);
    set_desc(opc, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1;
    chk({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, " valid_early"}, {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk({tag, " out_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, " instr"}, out_instr, exp_instr);
    chk({tag, " err"}, {31'b0, out_err}, {31'b0, exp_err});
  endtask

  logic [31:0] bp_desc [3];
  logic [31:0] got [$];
  int          n_acc;
  logic        c_acc;
  logic        seen;

  initial begin
    #2;
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst out_instr", out_instr, 32'h0);
    chk("rst out_err", {31'b0, out_err}, 32'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    encode_one("add",    5'b01100, 5'd3,  5'd1, 5'd2, 3'b000, 1'b0, 32'd0,         32'h002081B3, 1'b0);
    encode_one("sub",    5'b01100, 5'd5,  5'd6, 5'd7, 3'b000, 1'b1, 32'd0,         32'h407302B3, 1'b0);
    encode_one("op_f7",  5'b01100, 5'd5,  5'd6, 5'd7, 3'b001, 1'b1, 32'd0,         32'h0,        1'b1);
    encode_one("addi-1", 5'b00100, 5'd1,  5'd0, 5'd0, 3'b000, 1'b0, 32'hFFFFFFFF,  32'hFFF00093, 1'b0);
    encode_one("addi2k", 5'b00100, 5'd1,  5'd0, 5'd0, 3'b000, 1'b0, 32'd2048,      32'h0,        1'b1);
    encode_one("srai",   5'b00100, 5'd1,  5'd2, 5'd0, 3'b101, 1'b1, 32'd3,         32'h40315093, 1'b0);
    encode_one("slli32", 5'b00100, 5'd1,  5'd2, 5'd0, 3'b001, 1'b0, 32'd32,        32'h0,        1'b1);
    encode_one("beq",    5'b11000, 5'd0,  5'd1, 5'd2, 3'b000, 1'b0, 32'd8,         32'h00208463, 1'b0);
    encode_one("b_odd",  5'b11000, 5'd0,  5'd1, 5'd2, 3'b000, 1'b0, 32'd7,         32'h0,        1'b1);
    encode_one("b_f3",   5'b11000, 5'd0,  5'd1, 5'd2, 3'b010, 1'b0, 32'd8,         32'h0,        1'b1);
    encode_one("jal",    5'b11011, 5'd1,  5'd0, 5'd0, 3'b000, 1'b0, 32'd2048,      32'h001000EF, 1'b0);
    encode_one("ebreak", 5'b11100, 5'd0,  5'd0, 5'd0, 3'b000, 1'b0, 32'd1,         32'h00100073, 1'b0);
    encode_one("sys2",   5'b11100, 5'd0,  5'd0, 5'd0, 3'b000, 1'b0, 32'd2,         32'h0,        1'b1);
    encode_one("sw",     5'b01000, 5'd0,  5'd1, 5'd2, 3'b010, 1'b0, 32'hFFFFFFFC,  32'hFE20AE23, 1'b0);
    encode_one("lui",    5'b01101, 5'd10, 5'd0, 5'd0, 3'b000, 1'b0, 32'h12345000,  32'h12345537, 1'b0);
    encode_one("lui_lo", 5'b01101, 5'd10, 5'd0, 5'd0, 3'b000, 1'b0, 32'h12345001,  32'h0,        1'b1);
    encode_one("ld_f3",  5'b00000, 5'd1,  5'd2, 5'd0, 3'b011, 1'b0, 32'd0,         32'h0,        1'b1);
    encode_one("badopc", 5'b11111, 5'd1,  5'd2, 5'd3, 3'b000, 1'b0, 32'd0,         32'h0,        1'b1);

    // Backpressure: three ADDIs offered back to back while the consumer stalls.
    bp_desc[0] = 32'h00100093;
    bp_desc[1] = 32'h00200113;
    bp_desc[2] = 32'h00300193;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 3; i++) begin
      set_desc(5'b00100, 5'(n_acc + 1), 5'd0, 5'd0, 3'b000, 1'b0, 32'(n_acc + 1));
      in_valid = 1'b1;
      if (in_ready) n_acc++;
      @(posedge clk); #1;
    end
    chk("bp accepted", n_acc, 32'd2);
    chk("bp in_ready", {31'b0, in_ready}, 32'd0);
    chk("bp hold instr", out_instr, bp_desc[0]);
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) got.push_back(out_instr);
      c_acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (c_acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("bp count", got.size(), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < got.size()) chk("bp order", got[i], bp_desc[i]);

    // Reset with both stages full.
    out_ready = 1'b0;
    set_desc(5'b00100, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    set_desc(5'b00100, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("full in_ready", {31'b0, in_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid rst in_ready", {31'b0, in_ready}, 32'd1);
    chk("mid rst out_instr", out_instr, 32'h0);
    #4 rst = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("no stale word", {31'b0, seen}, 32'd0);

    // Statistics: five words, one of them an error.
    encode_one("st1", 5'b01100, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 32'd0,    32'h002081B3, 1'b0);
    encode_one("st2", 5'b00100, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2048, 32'h0,        1'b1);
    encode_one("st3", 5'b11000, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd8,    32'h00208463, 1'b0);
    encode_one("st4", 5'b11011, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2048, 32'h001000EF, 1'b0);
    encode_one("st5", 5'b11100, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 32'd0,    32'h00000073, 1'b0);
    @(posedge clk); #1;
`ifdef INSTR_ENCODER_STATS_EN
    chk("stat_enc", {16'b0, stat_enc}, 32'd5);
    chk("stat_err", {16'b0, stat_err}, 32'd1);
`else
    chk("stat_enc tied", {16'b0, stat_enc}, 32'd0);
    chk("stat_err tied", {16'b0, stat_err}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
